instruction_loader: RTL and testbench

Serial boot loader and instruction memory for the Hack CPU, sitting directly upstream of the CPU's `inst` input. It receives a framed program image over an 8N1 UART line and writes it into a 32K×16 instruction RAM. It holds the CPU in reset until a complete, checksum-verified image is present. It then serves `inst = mem[pc]` combinationally, as the CPU's single-cycle fetch requires.

---
 rtl/instruction_loader.sv | 197 +++++++++++++++++++
 tb/tb_instruction_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Serial UART boot loader and 32Kx16 instruction RAM for the Hack CPU.
// Holds the CPU in reset until a framed, checksum-verified image has been loaded.
module instruction_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH        = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] pc,
  output logic [15:0] inst,
  output logic        cpu_reset,
  output logic        loading,
  output logic        load_err
);

  localparam int unsigned AW   = 15;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CSUM, S_RUN
  } state_t;

  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    rx_byte, rx_byte_n;
  logic          rx_meta, rx_s, rx_d;
  logic          rx_valid, rx_valid_n, rx_ferr, rx_ferr_n;

  state_t      state, state_n;
  logic [15:0] len, len_n, addr, addr_n, full_len;
  logic [7:0]  sum, sum_n, hi, hi_n;
  logic        err_n, we_c;

  logic [15:0] mem [DEPTH];

  // Bit 15 of the program counter does not address memory.
  logic unused_pc;
  assign unused_pc = pc[15];

  // UART receiver: start edge, mid-bit start re-check, 8 data bits LSB first, stop bit.
  always_comb begin
    rx_state_n = rx_state;
    cnt_n      = cnt + CW'(1);
    bit_idx_n  = bit_idx;
    rx_byte_n  = rx_byte;
    rx_valid_n = 1'b0;
    rx_ferr_n  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_d && !rx_s) rx_state_n = RX_START;
      end
      RX_START: if (cnt == CW'(HALF - 1)) begin
        cnt_n      = '0;
        bit_idx_n  = '0;
        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt_n     = '0;
        rx_byte_n = {rx_s, rx_byte[7:1]};
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) rx_state_n = RX_STOP;
      end
      RX_STOP: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt_n      = '0;
        rx_valid_n = rx_s;
        rx_ferr_n  = !rx_s;
        rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_d     <= rx_s;
      rx_state <= rx_state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      rx_byte  <= rx_byte_n;
      rx_valid <= rx_valid_n;
      rx_ferr  <= rx_ferr_n;
    end
  end

  // Frame parser: sync, length, data words, checksum.
  always_comb begin
    state_n  = state;
    len_n    = len;
    addr_n   = addr;
    sum_n    = sum;
    hi_n     = hi;
    err_n    = load_err;
    we_c     = 1'b0;
    full_len = {len[15:8], rx_byte};
    if (rx_ferr && state != S_IDLE && state != S_RUN) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
    end else if (rx_valid) begin
      unique case (state)
        S_IDLE: if (rx_byte == SYNC) begin
          state_n = S_LEN_H;
          err_n   = 1'b0;
          addr_n  = '0;
          sum_n   = '0;
        end
        S_LEN_H: begin
          len_n   = {rx_byte, 8'h00};
          state_n = S_LEN_L;
        end
        S_LEN_L: begin
          len_n = full_len;
          if (full_len == '0) begin
            state_n = S_CSUM;
          end else if (32'(full_len) > DEPTH) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
          end else begin
            state_n = S_DATA_H;
          end
        end
        S_DATA_H: begin
          hi_n    = rx_byte;
          sum_n   = sum + rx_byte;
          state_n = S_DATA_L;
        end
        S_DATA_L: begin
          we_c    = 1'b1;
          addr_n  = addr + 16'd1;
          sum_n   = sum + rx_byte;
          state_n = (addr_n == len) ? S_CSUM : S_DATA_H;
        end
        S_CSUM: begin
          if (rx_byte == sum) begin
            state_n = S_RUN;
          end else begin
            state_n = S_IDLE;
            err_n   = 1'b1;
          end
        end
        S_RUN: if (rx_byte == SYNC) begin
          state_n = S_LEN_H;
          addr_n  = '0;
          sum_n   = '0;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      len       <= '0;
      addr      <= '0;
      sum       <= '0;
      hi        <= '0;
      load_err  <= 1'b0;
      cpu_reset <= 1'b1;
      loading   <= 1'b0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      addr      <= addr_n;
      sum       <= sum_n;
      hi        <= hi_n;
      load_err  <= err_n;
      cpu_reset <= (state_n != S_RUN);
      loading   <= (state_n != S_IDLE) && (state_n != S_RUN);
    end
  end

  // Instruction RAM: not reset, so a partial image survives reset.
  always_ff @(posedge clk) begin
    if (we_c) mem[addr[AW-1:0]] <= {hi, rx_byte};
  end

  assign inst = mem[pc[AW-1:0]];

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: UART frames in, scoreboard of expected
// status/memory values compared with immediate assertions.
`timescale 1ns/1ps
module tb_instruction_loader;

  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic [15:0] inst;
  logic        cpu_reset, loading, load_err;

  always #5 clk = ~clk;

  instruction_loader #(.CLKS_PER_BIT(CPB), .DEPTH(32768)) dut (
    .clk(clk), .reset(reset), .rx(rx), .pc(pc),
    .inst(inst), .cpu_reset(cpu_reset), .loading(loading), .load_err(load_err)
  );

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic expect_val(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    total++;
    assert (sb.size() != 0) else $error("FAIL scoreboard_empty observed=%h", obs);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit plus 8 data bits, LSB first; stop bit left to the caller.
  task automatic send_head(input logic [7:0] b);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_head(b);
    rx = stop;
    cycles(CPB);
    if (!stop) begin
      rx = 1'b1;
      cycles(CPB);
    end
  endtask

  task automatic sb_(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int viol;
    int n;

    // Reset state and idle stability
    expect_val("rst_cpu_reset", 16'd1);
    expect_val("rst_loading",   16'd0);
    expect_val("rst_load_err",  16'd0);
    expect_val("rst_stable",    16'd0);
    reset = 1'b0;
    rx    = 1'b1;
    cycles(5);
    reset = 1'b1;
    cycles(2);
    check(16'(cpu_reset));
    check(16'(loading));
    check(16'(load_err));
    viol = 0;
    for (int i = 0; i < 10000; i++) begin
      cycles(1);
      if (cpu_reset !== 1'b1 || loading !== 1'b0 || load_err !== 1'b0) viol++;
    end
    check(16'(viol));

    // Good two-word load with back-to-back bytes
    expect_val("good_pre_csum_reset",   16'd1);
    expect_val("good_pre_csum_loading", 16'd1);
    expect_val("good_fall_window",      16'd1);
    expect_val("good_load_err",         16'd0);
    expect_val("good_loading",          16'd0);
    expect_val("good_inst_pc0",         16'h0005);
    expect_val("good_inst_pc1",         16'hEC10);
    expect_val("good_inst_pc8001",      16'hEC10);
    sb_(8'hA5); sb_(8'h00); sb_(8'h02);
    sb_(8'h00); sb_(8'h05); sb_(8'hEC); sb_(8'h10);
    check(16'(cpu_reset));
    check(16'(loading));
    send_head(8'h01);
    rx = 1'b1;
    n  = 0;
    while (cpu_reset === 1'b1 && n < 2 * CPB) begin
      cycles(1);
      n++;
    end
    check(16'(n >= 8 && n <= CPB));
    if (n < CPB) cycles(CPB - n);
    check(16'(load_err));
    check(16'(loading));
    pc = 16'h0000; #1; check(inst);
    pc = 16'h0001; #1; check(inst);
    pc = 16'h8001; #1; check(inst);

    // Bad checksum from RUN
    expect_val("bad_load_err",     16'd1);
    expect_val("bad_cpu_reset",    16'd1);
    expect_val("bad_loading",      16'd0);
    expect_val("bad_partial_mem0", 16'h1234);
    sb_(8'hA5); sb_(8'h00); sb_(8'h01); sb_(8'h12); sb_(8'h34); sb_(8'h00);
    check(16'(load_err));
    check(16'(cpu_reset));
    check(16'(loading));
    pc = 16'h0000; #1; check(inst);

    // Sync clears the error; a short glitch mid-frame delivers no byte
    expect_val("sync_clears_err", 16'd0);
    expect_val("sync_loading",    16'd1);
    expect_val("glitch_run",      16'd0);
    expect_val("glitch_load_err", 16'd0);
    expect_val("glitch_mem0",     16'h5678);
    sb_(8'hA5);
    check(16'(load_err));
    check(16'(loading));
    rx = 1'b0;
    cycles(CPB / 4);
    rx = 1'b1;
    cycles(2 * CPB);
    sb_(8'h00); sb_(8'h01); sb_(8'h56); sb_(8'h78); sb_(8'hCE);
    check(16'(cpu_reset));
    check(16'(load_err));
    pc = 16'h0000; #1; check(inst);

    // Framing error on LEN_L
    expect_val("ferr_load_err",  16'd1);
    expect_val("ferr_loading",   16'd0);
    expect_val("ferr_cpu_reset", 16'd1);
    sb_(8'hA5); sb_(8'h00);
    send_byte(8'h01, 1'b0);
    check(16'(load_err));
    check(16'(loading));
    check(16'(cpu_reset));

    // Zero-length image runs without touching memory
    expect_val("zero_run",  16'd0);
    expect_val("zero_err",  16'd0);
    expect_val("zero_mem0", 16'h5678);
    sb_(8'hA5); sb_(8'h00); sb_(8'h00); sb_(8'h00);
    check(16'(cpu_reset));
    check(16'(load_err));
    check(inst);

    // Length just over and exactly at capacity
    expect_val("over_err",       16'd1);
    expect_val("over_loading",   16'd0);
    expect_val("over_cpu_reset", 16'd1);
    expect_val("max_loading",    16'd1);
    expect_val("max_err",        16'd0);
    sb_(8'hA5); sb_(8'h80); sb_(8'h01);
    check(16'(load_err));
    check(16'(loading));
    check(16'(cpu_reset));
    sb_(8'hA5); sb_(8'h80); sb_(8'h00);
    check(16'(loading));
    check(16'(load_err));

    // Three words into the full-size frame, then asynchronous reset
    expect_val("mid_loading",  16'd1);
    expect_val("rr_cpu_reset", 16'd1);
    expect_val("rr_loading",   16'd0);
    expect_val("rr_err",       16'd0);
    expect_val("rr_mem0",      16'h1111);
    expect_val("rr_mem1",      16'h2222);
    expect_val("rr_mem2",      16'h3333);
    sb_(8'h11); sb_(8'h11); sb_(8'h22); sb_(8'h22); sb_(8'h33); sb_(8'h33);
    check(16'(loading));
    reset = 1'b0;
    #1;
    check(16'(cpu_reset));
    check(16'(loading));
    check(16'(load_err));
    cycles(3);
    reset = 1'b1;
    cycles(2);
    pc = 16'h0000; #1; check(inst);
    pc = 16'h0001; #1; check(inst);
    pc = 16'h0002; #1; check(inst);

    // Reprogramming from RUN
    expect_val("rp_run",         16'd0);
    expect_val("rp_sync_reset",  16'd1);
    expect_val("rp_mid_reset",   16'd1);
    expect_val("rp_final_reset", 16'd0);
    expect_val("rp_err",         16'd0);
    expect_val("rp_mem0",        16'hABCD);
    expect_val("rp_mem1",        16'h2222);
    sb_(8'hA5); sb_(8'h00); sb_(8'h00); sb_(8'h00);
    check(16'(cpu_reset));
    sb_(8'hA5);
    check(16'(cpu_reset));
    sb_(8'h00); sb_(8'h01); sb_(8'hAB); sb_(8'hCD);
    check(16'(cpu_reset));
    sb_(8'h78);
    check(16'(cpu_reset));
    check(16'(load_err));
    pc = 16'h0000; #1; check(inst);
    pc = 16'h0001; #1; check(inst);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
